// File: rtl/core_writeback_if.sv
// Result/write-port/scoreboard bundle between the execution units, dispatch and core_writeback.
// CORE_WB_BYPASS_EN adds the fwd_* forwarding signals.
interface core_wb_if;
    logic        issue_alu_a, issue_alu_b, issue_mul, issue_ldst, issue_branch;
    logic [3:0]  issue_rd_alu_a, issue_rd_alu_b, issue_rd_mul, issue_rd_ldst, issue_rd_branch;
    logic        res_valid_alu_a, res_valid_alu_b, res_valid_mul, res_valid_ldst, res_valid_branch;
    logic [3:0]  res_rd_alu_a, res_rd_alu_b, res_rd_mul, res_rd_ldst, res_rd_branch;
    logic [31:0] res_value_alu_a, res_value_alu_b, res_value_mul, res_value_ldst, res_value_branch;
    logic        res_ready_alu_a, res_ready_alu_b, res_ready_mul, res_ready_ldst, res_ready_branch;
    logic        wr_en_a, wr_en_b;
    logic [3:0]  wr_r_a, wr_r_b;
    logic [31:0] wr_value_a, wr_value_b;
    logic [15:0] mask_alu_a, mask_alu_b, mask_mul, mask_ldst, mask_branch;
    logic        wb_stall_branch;
`ifdef CORE_WB_BYPASS_EN
    logic        fwd_en_a, fwd_en_b;
    logic [3:0]  fwd_r_a, fwd_r_b;
    logic [31:0] fwd_value_a, fwd_value_b;
`endif

    modport slave (
        input  issue_alu_a, issue_alu_b, issue_mul, issue_ldst, issue_branch,
        input  issue_rd_alu_a, issue_rd_alu_b, issue_rd_mul, issue_rd_ldst, issue_rd_branch,
        input  res_valid_alu_a, res_valid_alu_b, res_valid_mul, res_valid_ldst, res_valid_branch,
        input  res_rd_alu_a, res_rd_alu_b, res_rd_mul, res_rd_ldst, res_rd_branch,
        input  res_value_alu_a, res_value_alu_b, res_value_mul, res_value_ldst, res_value_branch,
        output res_ready_alu_a, res_ready_alu_b, res_ready_mul, res_ready_ldst, res_ready_branch,
        output wr_en_a, wr_en_b, wr_r_a, wr_r_b, wr_value_a, wr_value_b,
        output mask_alu_a, mask_alu_b, mask_mul, mask_ldst, mask_branch,
`ifdef CORE_WB_BYPASS_EN
        output fwd_en_a, fwd_en_b, fwd_r_a, fwd_r_b, fwd_value_a, fwd_value_b,
`endif
        output wb_stall_branch
    );

    modport master (
        output issue_alu_a, issue_alu_b, issue_mul, issue_ldst, issue_branch,
        output issue_rd_alu_a, issue_rd_alu_b, issue_rd_mul, issue_rd_ldst, issue_rd_branch,
        output res_valid_alu_a, res_valid_alu_b, res_valid_mul, res_valid_ldst, res_valid_branch,
        output res_rd_alu_a, res_rd_alu_b, res_rd_mul, res_rd_ldst, res_rd_branch,
        output res_value_alu_a, res_value_alu_b, res_value_mul, res_value_ldst, res_value_branch,
        input  res_ready_alu_a, res_ready_alu_b, res_ready_mul, res_ready_ldst, res_ready_branch,
        input  wr_en_a, wr_en_b, wr_r_a, wr_r_b, wr_value_a, wr_value_b,
        input  mask_alu_a, mask_alu_b, mask_mul, mask_ldst, mask_branch,
`ifdef CORE_WB_BYPASS_EN
        input  fwd_en_a, fwd_en_b, fwd_r_a, fwd_r_b, fwd_value_a, fwd_value_b,
`endif
        input  wb_stall_branch
    );
endinterface

// File: rtl/core_writeback.sv
// Two-port write-back arbiter (ldst > mul > branch > alu_a > alu_b) with per-unit pending-rd masks.
// CORE_WB_BYPASS_EN: masks clear on the grant edge and fwd_* mirror the write ports.
module core_writeback (
    input  logic      clk,
    input  logic      rst_n,
    core_wb_if.slave  wb
);
    localparam int NU = 5;

    // Unit index order doubles as grant priority: 0 ldst, 1 mul, 2 branch, 3 alu_a, 4 alu_b.
    logic [NU-1:0]        vld, iss, grant;
    logic [NU-1:0][3:0]   rd, iss_rd;
    logic [NU-1:0][31:0]  val;

    assign vld    = {wb.res_valid_alu_b, wb.res_valid_alu_a, wb.res_valid_branch,
                     wb.res_valid_mul, wb.res_valid_ldst} & {NU{rst_n}};
    assign rd     = {wb.res_rd_alu_b, wb.res_rd_alu_a, wb.res_rd_branch,
                     wb.res_rd_mul, wb.res_rd_ldst};
    assign val    = {wb.res_value_alu_b, wb.res_value_alu_a, wb.res_value_branch,
                     wb.res_value_mul, wb.res_value_ldst};
    assign iss    = {wb.issue_alu_b, wb.issue_alu_a, wb.issue_branch,
                     wb.issue_mul, wb.issue_ldst};
    assign iss_rd = {wb.issue_rd_alu_b, wb.issue_rd_alu_a, wb.issue_rd_branch,
                     wb.issue_rd_mul, wb.issue_rd_ldst};

    logic       g0_found, g1_found;
    logic [2:0] g0, g1;

    // Second grant skips any source whose rd collides with the first grant.
    always_comb begin
        g0_found = 1'b0;
        g1_found = 1'b0;
        g0       = 3'd0;
        g1       = 3'd0;
        grant    = '0;
        for (int i = 0; i < NU; i++) begin
            if (vld[i]) begin
                if (!g0_found) begin
                    g0_found = 1'b1;
                    g0       = 3'(i);
                end else if (!g1_found && rd[i] != rd[g0]) begin
                    g1_found = 1'b1;
                    g1       = 3'(i);
                end
            end
        end
        if (g0_found) grant[g0] = 1'b1;
        if (g1_found) grant[g1] = 1'b1;
    end

    logic        wr_en_a_q, wr_en_a_d, wr_en_b_q, wr_en_b_d;
    logic [3:0]  wr_r_a_q, wr_r_a_d, wr_r_b_q, wr_r_b_d;
    logic [31:0] wr_value_a_q, wr_value_a_d, wr_value_b_q, wr_value_b_d;
    logic [2:0]  src_a_q, src_a_d, src_b_q, src_b_d;

    always_comb begin
        wr_en_a_d    = g0_found;
        wr_r_a_d     = g0_found ? rd[g0]  : 4'd0;
        wr_value_a_d = g0_found ? val[g0] : 32'd0;
        src_a_d      = g0;
        wr_en_b_d    = g1_found;
        wr_r_b_d     = g1_found ? rd[g1]  : 4'd0;
        wr_value_b_d = g1_found ? val[g1] : 32'd0;
        src_b_d      = g1;
    end

    logic [NU-1:0][15:0] mask_q, mask_d, clr, set;

    // Set after clear so a re-issue to the same rd keeps the bit pending.
    always_comb begin
        clr = '0;
        set = '0;
`ifdef CORE_WB_BYPASS_EN
        if (g0_found) clr[g0][rd[g0]] = 1'b1;
        if (g1_found) clr[g1][rd[g1]] = 1'b1;
`else
        if (wr_en_a_q) clr[src_a_q][wr_r_a_q] = 1'b1;
        if (wr_en_b_q) clr[src_b_q][wr_r_b_q] = 1'b1;
`endif
        for (int i = 0; i < NU; i++) begin
            if (iss[i]) set[i][iss_rd[i]] = 1'b1;
        end
        mask_d = (mask_q & ~clr) | set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_a_q    <= 1'b0;
            wr_en_b_q    <= 1'b0;
            wr_r_a_q     <= 4'd0;
            wr_r_b_q     <= 4'd0;
            wr_value_a_q <= 32'd0;
            wr_value_b_q <= 32'd0;
            src_a_q      <= 3'd0;
            src_b_q      <= 3'd0;
            mask_q       <= '0;
        end else begin
            wr_en_a_q    <= wr_en_a_d;
            wr_en_b_q    <= wr_en_b_d;
            wr_r_a_q     <= wr_r_a_d;
            wr_r_b_q     <= wr_r_b_d;
            wr_value_a_q <= wr_value_a_d;
            wr_value_b_q <= wr_value_b_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            mask_q       <= mask_d;
        end
    end

    assign wb.res_ready_ldst   = grant[0];
    assign wb.res_ready_mul    = grant[1];
    assign wb.res_ready_branch = grant[2];
    assign wb.res_ready_alu_a  = grant[3];
    assign wb.res_ready_alu_b  = grant[4];
    assign wb.wb_stall_branch  = wb.res_valid_branch & ~grant[2];

    assign wb.wr_en_a    = wr_en_a_q;
    assign wb.wr_en_b    = wr_en_b_q;
    assign wb.wr_r_a     = wr_r_a_q;
    assign wb.wr_r_b     = wr_r_b_q;
    assign wb.wr_value_a = wr_value_a_q;
    assign wb.wr_value_b = wr_value_b_q;

    assign wb.mask_ldst   = mask_q[0];
    assign wb.mask_mul    = mask_q[1];
    assign wb.mask_branch = mask_q[2];
    assign wb.mask_alu_a  = mask_q[3];
    assign wb.mask_alu_b  = mask_q[4];

`ifdef CORE_WB_BYPASS_EN
    assign wb.fwd_en_a    = wr_en_a_q;
    assign wb.fwd_en_b    = wr_en_b_q;
    assign wb.fwd_r_a     = wr_r_a_q;
    assign wb.fwd_r_b     = wr_r_b_q;
    assign wb.fwd_value_a = wr_value_a_q;
    assign wb.fwd_value_b = wr_value_b_q;
`endif
endmodule

// File: tb/tb_core_writeback.sv
// Directed bench for core_writeback: stimulus queues expected port writes, a monitor checks them.
module tb_core_writeback;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_wb_if wb();
    core_writeback dut (.clk(clk), .rst_n(rst_n), .wb(wb));

    typedef struct packed {
        logic [3:0]  ra;
        logic [31:0] va;
        logic        enb;
        logic [3:0]  rb;
        logic [31:0] vb;
    } wr_t;

    wr_t sb[$];
    int  errs = 0;
    int  checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [3:0] ra, input logic [31:0] va, input logic enb,
                          input logic [3:0] rb, input logic [31:0] vb);
        wr_t e;
        e = '{ra, va, enb, rb, vb};
        sb.push_back(e);
    endtask

    function automatic logic [4:0] rdy();
        return {wb.res_ready_alu_b, wb.res_ready_alu_a, wb.res_ready_branch,
                wb.res_ready_mul, wb.res_ready_ldst};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle with an active write port consumes one expectation.
    always @(negedge clk) begin
        wr_t act, e;
        if (rst_n && (wb.wr_en_a || wb.wr_en_b)) begin
            act = '{wb.wr_r_a, wb.wr_value_a, wb.wr_en_b,
                    wb.wr_en_b ? wb.wr_r_b : 4'h0, wb.wr_en_b ? wb.wr_value_b : 32'h0};
            checks++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL wr_unexpected: got en_a=%0b ra=%0h va=%0h en_b=%0b rb=%0h vb=%0h",
                         wb.wr_en_a, act.ra, act.va, act.enb, act.rb, act.vb);
            end else begin
                e = sb.pop_front();
                if (!wb.wr_en_a || act !== e) begin
                    errs++;
                    $display("FAIL wr_ports: got en_a=%0b ra=%0h va=%0h en_b=%0b rb=%0h vb=%0h expected en_a=1 ra=%0h va=%0h en_b=%0b rb=%0h vb=%0h",
                             wb.wr_en_a, act.ra, act.va, act.enb, act.rb, act.vb,
                             e.ra, e.va, e.enb, e.rb, e.vb);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        {wb.issue_alu_a, wb.issue_alu_b, wb.issue_mul, wb.issue_ldst, wb.issue_branch} = '0;
        {wb.issue_rd_alu_a, wb.issue_rd_alu_b, wb.issue_rd_mul, wb.issue_rd_ldst, wb.issue_rd_branch} = '0;
        {wb.res_valid_alu_a, wb.res_valid_alu_b, wb.res_valid_mul, wb.res_valid_ldst, wb.res_valid_branch} = '0;
        {wb.res_rd_alu_a, wb.res_rd_alu_b, wb.res_rd_mul, wb.res_rd_ldst, wb.res_rd_branch} = '0;
        {wb.res_value_alu_a, wb.res_value_alu_b, wb.res_value_mul, wb.res_value_ldst, wb.res_value_branch} = '0;

        // Reset state, with a source asserting valid during reset
        wb.res_valid_ldst = 1'b1;
        #12;
        chk("rst_ready", 32'(rdy()), 32'h0);
        chk("rst_wr_en", {30'd0, wb.wr_en_a, wb.wr_en_b}, 32'h0);
        chk("rst_wr_a", {28'd0, wb.wr_r_a} | wb.wr_value_a, 32'h0);
        chk("rst_masks", 32'(wb.mask_alu_a | wb.mask_alu_b | wb.mask_mul | wb.mask_ldst | wb.mask_branch), 32'h0);
        wb.res_valid_ldst = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // Single alu_a result
        wb.res_valid_alu_a = 1'b1; wb.res_rd_alu_a = 4'd3; wb.res_value_alu_a = 32'h1234;
        #1 chk("t1_ready", 32'(rdy()), 32'b01000);
        exp_wr(4'd3, 32'h1234, 1'b0, 4'd0, 32'd0);
        cyc();
        wb.res_valid_alu_a = 1'b0;
        chk("t1_wr_en_b", 32'(wb.wr_en_b), 32'h0);

        // ldst issue rd=5, result four cycles later
        wb.issue_ldst = 1'b1; wb.issue_rd_ldst = 4'd5;
        cyc();
        wb.issue_ldst = 1'b0;
        chk("t2_mask_set", 32'(wb.mask_ldst), 32'h0020);
        cyc(); cyc(); cyc();
        wb.res_valid_ldst = 1'b1; wb.res_rd_ldst = 4'd5; wb.res_value_ldst = 32'hA5;
        #1 chk("t2_ready", 32'(rdy()), 32'b00001);
        exp_wr(4'd5, 32'hA5, 1'b0, 4'd0, 32'd0);
        cyc();
        wb.res_valid_ldst = 1'b0;
`ifdef CORE_WB_BYPASS_EN
        chk("t2_mask_wrcycle", 32'(wb.mask_ldst), 32'h0000);
`else
        chk("t2_mask_wrcycle", 32'(wb.mask_ldst), 32'h0020);
`endif
        cyc();
        chk("t2_mask_clr", 32'(wb.mask_ldst), 32'h0000);

        // All five valid, distinct rd
        wb.res_valid_ldst = 1'b1;   wb.res_rd_ldst = 4'd1;   wb.res_value_ldst = 32'h11;
        wb.res_valid_mul = 1'b1;    wb.res_rd_mul = 4'd2;    wb.res_value_mul = 32'h22;
        wb.res_valid_branch = 1'b1; wb.res_rd_branch = 4'd4; wb.res_value_branch = 32'h44;
        wb.res_valid_alu_a = 1'b1;  wb.res_rd_alu_a = 4'd6;  wb.res_value_alu_a = 32'h66;
        wb.res_valid_alu_b = 1'b1;  wb.res_rd_alu_b = 4'd8;  wb.res_value_alu_b = 32'h88;
        #1 chk("t3_ready_c0", 32'(rdy()), 32'b00011);
        chk("t3_stall_c0", 32'(wb.wb_stall_branch), 32'h1);
        exp_wr(4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
        cyc();
        wb.res_valid_ldst = 1'b0; wb.res_valid_mul = 1'b0;
        #1 chk("t3_ready_c1", 32'(rdy()), 32'b01100);
        chk("t3_stall_c1", 32'(wb.wb_stall_branch), 32'h0);
        exp_wr(4'd4, 32'h44, 1'b1, 4'd6, 32'h66);
        cyc();
        wb.res_valid_branch = 1'b0; wb.res_valid_alu_a = 1'b0;
        #1 chk("t3_ready_c2", 32'(rdy()), 32'b10000);
        chk("t3_stall_c2", 32'(wb.wb_stall_branch), 32'h0);
        exp_wr(4'd8, 32'h88, 1'b0, 4'd0, 32'd0);
        cyc();
        wb.res_valid_alu_b = 1'b0;

        // Same-rd conflict: alu_a skipped, alu_b takes port B
        wb.res_valid_ldst = 1'b1;  wb.res_rd_ldst = 4'd7;  wb.res_value_ldst = 32'h700;
        wb.res_valid_alu_a = 1'b1; wb.res_rd_alu_a = 4'd7; wb.res_value_alu_a = 32'h701;
        wb.res_valid_alu_b = 1'b1; wb.res_rd_alu_b = 4'd9; wb.res_value_alu_b = 32'h902;
        #1 chk("t4_ready_c0", 32'(rdy()), 32'b10001);
        exp_wr(4'd7, 32'h700, 1'b1, 4'd9, 32'h902);
        cyc();
        wb.res_valid_ldst = 1'b0; wb.res_valid_alu_b = 1'b0;
        #1 chk("t4_ready_c1", 32'(rdy()), 32'b01000);
        exp_wr(4'd7, 32'h701, 1'b0, 4'd0, 32'd0);
        cyc();
        wb.res_valid_alu_a = 1'b0;

        // Re-issue alu_b rd=2 in the cycle its previous result is written
        wb.issue_alu_b = 1'b1; wb.issue_rd_alu_b = 4'd2;
        cyc();
        wb.issue_alu_b = 1'b0;
        chk("t5_mask_set", 32'(wb.mask_alu_b), 32'h0004);
        wb.res_valid_alu_b = 1'b1; wb.res_rd_alu_b = 4'd2; wb.res_value_alu_b = 32'hB2;
        #1 chk("t5_ready", 32'(rdy()), 32'b10000);
        exp_wr(4'd2, 32'hB2, 1'b0, 4'd0, 32'd0);
        cyc();
        wb.res_valid_alu_b = 1'b0;
        wb.issue_alu_b = 1'b1; wb.issue_rd_alu_b = 4'd2;
        cyc();
        wb.issue_alu_b = 1'b0;
        chk("t5_mask_setwins", 32'(wb.mask_alu_b), 32'h0004);
        wb.res_valid_alu_b = 1'b1; wb.res_value_alu_b = 32'hB3;
        exp_wr(4'd2, 32'hB3, 1'b0, 4'd0, 32'd0);
        cyc();
        wb.res_valid_alu_b = 1'b0;
        cyc();
        chk("t5_mask_clr", 32'(wb.mask_alu_b), 32'h0000);

        // Asynchronous reset mid-operation
        wb.issue_mul = 1'b1;   wb.issue_rd_mul = 4'd10;
        wb.issue_alu_a = 1'b1; wb.issue_rd_alu_a = 4'd11;
        cyc();
        wb.issue_mul = 1'b0; wb.issue_alu_a = 1'b0;
        chk("t6_mask_mul", 32'(wb.mask_mul), 32'h0400);
        chk("t6_mask_alu_a", 32'(wb.mask_alu_a), 32'h0800);
        wb.res_valid_ldst = 1'b1; wb.res_rd_ldst = 4'd12; wb.res_value_ldst = 32'hC;
        cyc();
        wb.res_valid_ldst = 1'b0;
        chk("t6_wr_en_a_active", 32'(wb.wr_en_a), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_wr_en", {30'd0, wb.wr_en_a, wb.wr_en_b}, 32'h0);
        chk("t6_rst_masks", 32'(wb.mask_alu_a | wb.mask_alu_b | wb.mask_mul | wb.mask_ldst | wb.mask_branch), 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
